// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the UART receiver (and its tx_module counterpart):
//   - clocks-per-bit constants for the common clock/baud combinations
//   - the receiver state encoding
//   - a 2-of-3 majority helper used when RX_MAJORITY_EN is defined
// ---------------------------------------------------------------------------
package rx_pkg;

    localparam logic [12:0] BPS_50MHz_9600   = 13'd5208;
    localparam logic [12:0] BPS_50MHz_115200 = 13'd434;
    localparam logic [12:0] BPS_12MHz_9600   = 13'd1250;
    localparam logic [12:0] BPS_12MHz_115200 = 13'd104;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_bps_gen.sv
// ---------------------------------------------------------------------------
// rx_bps_gen
// Baud counter for the UART receiver. Counts 0..BPS/2-1 (half-bit select)
// or 0..BPS-1 (full-bit select), wraps, and strobes o_sample for one cycle
// at the end of each period.
// Build option: RX_MAJORITY_EN delays the strobe by one cycle so the
// receiver can decide on the majority of three samples centred on the
// nominal sample point.
//
// Ports:
//   clk        input   system clock, rising edge
//   rst_n      input   asynchronous active-low reset
//   i_clear    input   hold counter at zero, suppress strobe
//   i_half_sel input   1 = half-bit period, 0 = full-bit period
//   o_sample   output  one-cycle sample strobe
// ---------------------------------------------------------------------------
module rx_bps_gen #(
    parameter logic [12:0] BPS = 13'd434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_half_sel,
    output logic o_sample
);

    localparam logic [12:0] FULL_LAST = BPS - 13'd1;
    localparam logic [12:0] HALF_LAST = (BPS >> 1) - 13'd1;

    logic [12:0] r_count;
    logic [12:0] w_last;
    logic        w_hit;

    assign w_last = i_half_sel ? HALF_LAST : FULL_LAST;
    // >= rather than == so a counter left above a shorter period still wraps
    assign w_hit  = (r_count >= w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 13'd0;
        end else if (i_clear || w_hit) begin
            r_count <= 13'd0;
        end else begin
            r_count <= r_count + 13'd1;
        end
    end

`ifdef RX_MAJORITY_EN
    logic r_hit_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_d <= 1'b0;
        end else begin
            r_hit_d <= w_hit && !i_clear;
        end
    end

    assign o_sample = r_hit_d && !i_clear;
`else
    assign o_sample = w_hit && !i_clear;
`endif

endmodule

// File: rtl/rx_module.sv
// ---------------------------------------------------------------------------
// rx_module
// UART 8N1 receiver. Synchronises rx_pin, detects the start edge, samples
// start/data/stop bits with rx_bps_gen and presents each good byte on
// rx_data with a one-cycle rx_done pulse. A low stop bit gives a one-cycle
// frame_err pulse and the receiver waits for the line to return high.
// Build option: RX_MAJORITY_EN -> 2-of-3 majority around each sample point.
//
// Ports:
//   clk        input      system clock, rising edge
//   rst_n      input      asynchronous active-low reset
//   rx_en_sig  input      receiver enable; low aborts any frame
//   rx_pin     input      asynchronous serial line, idles high
//   rx_data    output [8] last correctly framed byte
//   rx_done    output     one-cycle pulse when rx_data updated
//   frame_err  output     one-cycle pulse on a low stop bit
// ---------------------------------------------------------------------------
module rx_module
    import rx_pkg::*;
#(
    parameter logic [12:0] BPS = BPS_50MHz_115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_en_sig,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err
);

    rx_state_t   r_state;
    rx_state_t   w_next_state;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_rx_data;
    logic        r_rx_done;
    logic        r_frame_err;

    logic        w_start_edge;
    logic        w_line;
    logic        w_sample;
    logic        w_clear;
    logic        w_half_sel;
    logic        w_shift_en;
    logic        w_load;
    logic        w_err;

    // Synchroniser flops reset high so releasing reset on an idle line does
    // not look like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rx_pin;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_start_edge = r_sync3 & ~r_sync2;

`ifdef RX_MAJORITY_EN
    logic r_sync4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync4 <= 1'b1;
        end else begin
            r_sync4 <= r_sync3;
        end
    end

    // The strobe arrives one cycle after the nominal point, so the three
    // newest samples straddle it.
    assign w_line = majority3(r_sync2, r_sync3, r_sync4);
`else
    assign w_line = r_sync2;
`endif

    rx_bps_gen #(
        .BPS        (BPS)
    ) u_bps_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_half_sel (w_half_sel),
        .o_sample   (w_sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The counter is not cleared on START -> DATA: it wraps at the half-bit
    // sample and already starts the first full bit from zero. Clearing there
    // would push later samples a cycle late when the decision is delayed.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_half_sel   = 1'b0;
        w_shift_en   = 1'b0;
        w_load       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear    = 1'b1;
                w_half_sel = 1'b1;
                if (rx_en_sig && w_start_edge) begin
                    w_next_state = START;
                end
            end
            START: begin
                w_half_sel = 1'b1;
                if (!rx_en_sig) begin
                    w_next_state = IDLE;
                end else if (w_sample) begin
                    w_next_state = w_line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (!rx_en_sig) begin
                    w_next_state = IDLE;
                end else if (w_sample) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (!rx_en_sig) begin
                    w_next_state = IDLE;
                end else if (w_sample) begin
                    if (w_line) begin
                        w_load       = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_err        = 1'b1;
                        w_next_state = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                w_clear = 1'b1;
                if (!rx_en_sig || r_sync2) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Data path: LSB arrives first, so bits enter at the top and move down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_rx_data   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {w_line, r_shift[7:1]};
            end
            if (r_state != DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_load) begin
                r_rx_data <= r_shift;
            end
            r_rx_done   <= w_load;
            r_frame_err <= w_err;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_rx_module.sv
// ---------------------------------------------------------------------------
// tb_rx_module
// Directed testbench for rx_module at BPS = 104. A serial driver plays the
// role of tx_module; a monitor on the falling clock edge records every
// rx_done / frame_err pulse. RX_MAJORITY_EN selects the majority build.
// ---------------------------------------------------------------------------
module tb_rx_module;
    import rx_pkg::*;

    localparam logic [12:0] BPS   = BPS_12MHz_115200;
    localparam int          BPS_I = int'(BPS);
    localparam int          GOFF  = BPS_I / 2 + 1;
`ifdef RX_MAJORITY_EN
    localparam int          EXP_LAT = BPS_I / 2 + 9 * BPS_I + 5;
`else
    localparam int          EXP_LAT = BPS_I / 2 + 9 * BPS_I + 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_en_sig;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;

    int         compared     = 0;
    int         mismatched   = 0;
    int         cycle        = 0;
    int         doneCount    = 0;
    int         errCount     = 0;
    int         overlapCount = 0;
    logic [7:0] dataQ[$];
    int         doneCycQ[$];
    int         startCycQ[$];

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         expDone;
        int         expErr;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs[6];

    rx_module #(
        .BPS       (BPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en_sig (rx_en_sig),
        .rx_pin    (rx_pin),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Record each output pulse on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_done) begin
            doneCount++;
            dataQ.push_back(rx_data);
            doneCycQ.push_back(cycle);
        end
        if (frame_err) errCount++;
        if (rx_done && frame_err) overlapCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendBit(input logic level, input bit glitch);
        for (int c = 0; c < BPS_I; c++) begin
            rx_pin = (glitch && c == GOFF) ? ~level : level;
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame; the line is left at the stop-bit level.
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input bit glitch);
        logic [9:0] fr;
        fr = {stopBit, d, 1'b0};
        startCycQ.push_back(cycle);
        for (int k = 0; k < 10; k++) sendBit(fr[k], glitch);
    endtask

    function automatic logic [31:0] latOk(input int di, input int si);
        int lat;
        if (di >= doneCycQ.size() || si >= startCycQ.size()) return 32'd0;
        lat = doneCycQ[di] - startCycQ[si];
        return (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] qData(input int idx);
        if (idx >= dataQ.size()) return 32'hFFFF_FFFF;
        return 32'(dataQ[idx]);
    endfunction

    initial begin
        int d0, e0, q0, c0, s0;

        vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
        vecs[1] = '{8'hAA, 1'b1, 1, 0, 8'hAA};
        vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[4] = '{8'hA5, 1'b0, 0, 1, 8'hFF};
        vecs[5] = '{8'h80, 1'b1, 1, 0, 8'h80};

        rst_n     = 1'b0;
        rx_en_sig = 1'b1;
        rx_pin    = 1'b1;
        idleCycles(5);
        checkOutput("reset_data", 32'(rx_data), 32'h00);
        checkOutput("reset_done", 32'(rx_done), 32'd0);
        checkOutput("reset_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        idleCycles(10);
        checkOutput("release_no_pulse", 32'(doneCount + errCount), 32'd0);

        // Back-to-back frames with a single stop bit
        $display("[TB] back-to-back frames");
        d0 = doneCount; e0 = errCount; q0 = dataQ.size(); c0 = doneCycQ.size(); s0 = startCycQ.size();
        applyStimulus(8'h2E, 1'b1, 1'b0);
        applyStimulus(8'h3F, 1'b1, 1'b0);
        applyStimulus(8'hDD, 1'b1, 1'b0);
        rx_pin = 1'b1;
        idleCycles(BPS_I);
        checkOutput("b2b_done", 32'(doneCount - d0), 32'd3);
        checkOutput("b2b_err", 32'(errCount - e0), 32'd0);
        checkOutput("b2b_byte0", qData(q0), 32'h2E);
        checkOutput("b2b_byte1", qData(q0 + 1), 32'h3F);
        checkOutput("b2b_byte2", qData(q0 + 2), 32'hDD);
        for (int k = 0; k < 3; k++) checkOutput("b2b_latency", latOk(c0 + k, s0 + k), 32'd1);

        // Table of isolated frames
        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            d0 = doneCount; e0 = errCount; c0 = doneCycQ.size(); s0 = startCycQ.size();
            applyStimulus(vecs[i].data, vecs[i].stopBit, 1'b0);
            rx_pin = 1'b1;
            idleCycles(BPS_I);
            checkOutput("vec_done", 32'(doneCount - d0), 32'(vecs[i].expDone));
            checkOutput("vec_err", 32'(errCount - e0), 32'(vecs[i].expErr));
            checkOutput("vec_data", 32'(rx_data), 32'(vecs[i].expData));
            if (vecs[i].expDone == 1) checkOutput("vec_latency", latOk(c0, s0), 32'd1);
        end

        // 100 ns low glitch on an idle line
        $display("[TB] start glitch");
        d0 = doneCount; e0 = errCount;
        rx_pin = 1'b0;
        idleCycles(5);
        rx_pin = 1'b1;
        idleCycles(2 * BPS_I);
        checkOutput("glitch_done", 32'(doneCount - d0), 32'd0);
        checkOutput("glitch_err", 32'(errCount - e0), 32'd0);

        // Enable rises while the line is already low
        $display("[TB] enable rising on low line");
        d0 = doneCount; e0 = errCount;
        rx_en_sig = 1'b0;
        rx_pin    = 1'b0;
        idleCycles(BPS_I);
        rx_en_sig = 1'b1;
        idleCycles(2 * BPS_I);
        rx_pin = 1'b1;
        idleCycles(BPS_I);
        checkOutput("enrise_pulses", 32'(doneCount - d0 + errCount - e0), 32'd0);

        // Enable dropped during bit 4 of 0xFF, then 0x01
        $display("[TB] enable abort");
        d0 = doneCount; e0 = errCount;
        sendBit(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) sendBit(1'b1, 1'b0);
        idleCycles(BPS_I / 2);
        rx_en_sig = 1'b0;
        idleCycles(3);
        rx_en_sig = 1'b1;
        idleCycles(5 * BPS_I);
        checkOutput("abort_pulses", 32'(doneCount - d0 + errCount - e0), 32'd0);
        checkOutput("abort_data", 32'(rx_data), 32'h80);
        applyStimulus(8'h01, 1'b1, 1'b0);
        rx_pin = 1'b1;
        idleCycles(BPS_I);
        checkOutput("after_abort_done", 32'(doneCount - d0), 32'd1);
        checkOutput("after_abort_data", 32'(rx_data), 32'h01);

        // Low stop bit followed by a 3-bit break, then 0x3C
        $display("[TB] framing error with break");
        d0 = doneCount; e0 = errCount;
        applyStimulus(8'hA5, 1'b0, 1'b0);
        idleCycles(3 * BPS_I);
        checkOutput("break_err", 32'(errCount - e0), 32'd1);
        checkOutput("break_done", 32'(doneCount - d0), 32'd0);
        checkOutput("break_data", 32'(rx_data), 32'h01);
        rx_pin = 1'b1;
        idleCycles(BPS_I);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        rx_pin = 1'b1;
        idleCycles(BPS_I);
        checkOutput("post_break_err", 32'(errCount - e0), 32'd1);
        checkOutput("post_break_done", 32'(doneCount - d0), 32'd1);
        checkOutput("post_break_data", 32'(rx_data), 32'h3C);

        // Reset mid-frame of 0x7E, then 0x81
        $display("[TB] reset mid-frame");
        d0 = doneCount; e0 = errCount;
        sendBit(1'b0, 1'b0);
        sendBit(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) sendBit(1'b1, 1'b0);
        rst_n  = 1'b0;
        rx_pin = 1'b1;
        idleCycles(5);
        checkOutput("midreset_data", 32'(rx_data), 32'h00);
        rst_n = 1'b1;
        idleCycles(2 * BPS_I);
        checkOutput("midreset_data_after", 32'(rx_data), 32'h00);
        checkOutput("midreset_pulses", 32'(doneCount - d0 + errCount - e0), 32'd0);
        applyStimulus(8'h81, 1'b1, 1'b0);
        rx_pin = 1'b1;
        idleCycles(BPS_I);
        checkOutput("post_reset_done", 32'(doneCount - d0), 32'd1);
        checkOutput("post_reset_data", 32'(rx_data), 32'h81);

`ifdef RX_MAJORITY_EN
        // One-cycle inverted glitch at the sample point of every bit
        $display("[TB] majority glitch rejection");
        d0 = doneCount; e0 = errCount;
        applyStimulus(8'h81, 1'b1, 1'b1);
        rx_pin = 1'b1;
        idleCycles(BPS_I);
        checkOutput("maj_done", 32'(doneCount - d0), 32'd1);
        checkOutput("maj_err", 32'(errCount - e0), 32'd0);
        checkOutput("maj_data", 32'(rx_data), 32'h81);
`endif

        checkOutput("done_err_overlap", 32'(overlapCount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
